// File: rtl/seg7_shift_out.sv
// Serialises one 8-bit segment pattern per valid/ready handshake into an external
// 74HC595 (SER / SRCLK / RCLK). Optionally drops a pattern equal to the last one latched.
module seg7_shift_out #(
    parameter int unsigned DIV       = 2,    // clk cycles per sr_clk half-period and latch width, 1..255
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          SKIP_SAME = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_in,
    input  logic       seg_valid,
    output logic       seg_ready,
    output logic       sr_data,
    output logic       sr_clk,
    output logic       sr_latch
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_div_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_pattern;
    logic [7:0]  r_last_sent;
    logic        r_primed;
    logic        r_sr_data;
    logic        r_sr_clk;
    logic        r_sr_latch;

    logic        w_accept;
    logic        w_skip;
    logic        w_div_done;
    logic        w_last_bit;
    logic        w_load;
    logic        w_advance;
    logic        w_finish;
    logic        w_sr_clk_next;
    logic        w_sr_latch_next;
    logic [7:0]  w_shift_next;
    logic        w_first_bit;
    logic        w_next_bit;

    // seg_ready is the only combinational output; it drops the instant reset rises.
    assign seg_ready  = (r_state == IDLE) && !reset;
    assign w_accept   = seg_valid && seg_ready;
    assign w_skip     = SKIP_SAME && r_primed && (seg_in == r_last_sent);
    assign w_div_done = (r_div_cnt == DIV_LAST);
    assign w_last_bit = (r_bit_cnt == 3'd7);

    assign w_shift_next = MSB_FIRST ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
    assign w_first_bit  = MSB_FIRST ? seg_in[7]  : seg_in[0];
    assign w_next_bit   = MSB_FIRST ? r_shift[6] : r_shift[1];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves w_state_next unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept && !w_skip) begin
                    w_state_next = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (w_div_done) begin
                    w_state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (w_div_done) begin
                    w_state_next = w_last_bit ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                if (w_div_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output / datapath-control decode; pin levels are registered from the next state.
    always_comb begin
        w_load          = (r_state == IDLE) && w_accept && !w_skip;
        w_advance       = (r_state == SHIFT_HI) && w_div_done && !w_last_bit;
        w_finish        = (r_state == LATCH) && w_div_done;
        w_sr_clk_next   = (w_state_next == SHIFT_HI);
        w_sr_latch_next = (w_state_next == LATCH);
    end

    // Datapath and registered pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt   <= 8'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_pattern   <= 8'd0;
            r_last_sent <= 8'hFF;
            r_primed    <= 1'b0;
            r_sr_data   <= 1'b0;
            r_sr_clk    <= 1'b0;
            r_sr_latch  <= 1'b0;
        end else begin
            // Divider restarts on every phase change and idles at zero.
            if ((r_state == IDLE) || (w_state_next != r_state)) begin
                r_div_cnt <= 8'd0;
            end else begin
                r_div_cnt <= r_div_cnt + 8'd1;
            end

            if (w_accept) begin
                r_shift <= seg_in;
            end else if (w_advance) begin
                r_shift <= w_shift_next;
            end

            if (w_load) begin
                r_pattern <= seg_in;
                r_bit_cnt <= 3'd0;
                r_sr_data <= w_first_bit;
            end else if (w_advance) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_sr_data <= w_next_bit;
            end

            // Only a completed latch pulse updates the duplicate filter.
            if (w_finish) begin
                r_last_sent <= r_pattern;
                r_primed    <= 1'b1;
            end

            r_sr_clk   <= w_sr_clk_next;
            r_sr_latch <= w_sr_latch_next;
        end
    end

    assign sr_data  = r_sr_data;
    assign sr_clk   = r_sr_clk;
    assign sr_latch = r_sr_latch;

endmodule

// File: tb/tb_seg7_shift_out.sv
// Bench for seg7_shift_out: four parameterisations driven against a 74HC595 pin-level
// model and cycle-exact waveform expectations derived from the timing rules.
module tb_seg7_shift_out;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] seg_in [4];
    logic [3:0] seg_valid;
    logic [3:0] seg_ready;
    logic [3:0] sr_data;
    logic [3:0] sr_clk;
    logic [3:0] sr_latch;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_shift_out #(.DIV(2), .MSB_FIRST(1'b1), .SKIP_SAME(1'b1)) u_msb (
        .clk(clk), .reset(reset), .seg_in(seg_in[0]), .seg_valid(seg_valid[0]),
        .seg_ready(seg_ready[0]), .sr_data(sr_data[0]), .sr_clk(sr_clk[0]), .sr_latch(sr_latch[0]));
    seg7_shift_out #(.DIV(2), .MSB_FIRST(1'b0), .SKIP_SAME(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .seg_in(seg_in[1]), .seg_valid(seg_valid[1]),
        .seg_ready(seg_ready[1]), .sr_data(sr_data[1]), .sr_clk(sr_clk[1]), .sr_latch(sr_latch[1]));
    seg7_shift_out #(.DIV(1), .MSB_FIRST(1'b1), .SKIP_SAME(1'b1)) u_fast (
        .clk(clk), .reset(reset), .seg_in(seg_in[2]), .seg_valid(seg_valid[2]),
        .seg_ready(seg_ready[2]), .sr_data(sr_data[2]), .sr_clk(sr_clk[2]), .sr_latch(sr_latch[2]));
    seg7_shift_out #(.DIV(3), .MSB_FIRST(1'b0), .SKIP_SAME(1'b1)) u_slow (
        .clk(clk), .reset(reset), .seg_in(seg_in[3]), .seg_valid(seg_valid[3]),
        .seg_ready(seg_ready[3]), .sr_data(sr_data[3]), .sr_clk(sr_clk[3]), .sr_latch(sr_latch[3]));

    // 74HC595 model per instance: q[0] = QA. SER shifts into QA on SRCLK rise, RCLK rise copies to outputs.
    logic [7:0] q595      [4];
    logic [7:0] ql595     [4];
    logic [7:0] latch_log [4][256];
    int         n_latch   [4];
    int         n_rise    [4];
    int         n_viol    [4];
    logic [3:0] prev_clk   = '0;
    logic [3:0] prev_latch = '0;
    logic [3:0] prev_data  = '0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            q595[i] = 8'h00; ql595[i] = 8'h00;
            n_latch[i] = 0; n_rise[i] = 0; n_viol[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (sr_clk[i] && !prev_clk[i]) begin
                q595[i]   <= {q595[i][6:0], sr_data[i]};
                n_rise[i] <= n_rise[i] + 1;
            end
            if (sr_latch[i] && !prev_latch[i]) begin
                ql595[i]                       <= q595[i];
                latch_log[i][n_latch[i] % 256] <= q595[i];
                n_latch[i]                     <= n_latch[i] + 1;
            end
            if (sr_clk[i] && prev_clk[i] && (sr_data[i] !== prev_data[i])) begin
                n_viol[i] <= n_viol[i] + 1;
            end
        end
        prev_clk   <= sr_clk;
        prev_latch <= sr_latch;
        prev_data  <= sr_data;
    end

    // Segment pattern seen on the 595 outputs: MSB-first puts segment A on QA,
    // LSB-first reads {QA..QH} as bit 7..0.
    function automatic logic [7:0] decode595(input logic [7:0] q, input bit msb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = msb ? q[i] : q[7-i];
        return r;
    endfunction

    task automatic send_pattern(input int idx, input logic [7:0] p, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        seg_in[idx]    = p;
        seg_valid[idx] = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (seg_ready[idx]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            seg_valid[idx] = 1'b0;
            $display("FAIL accept_timeout inst=%0d pattern=%h: seg_ready got 0, expected 1", idx, p);
        end else begin
            @(posedge clk);
        end
    endtask

    // Called right after the accepting edge T0; checks every cycle up to T0+17*DIV.
    task automatic check_transfer(input int idx, input logic [7:0] p, input int div, input bit msb);
        int   k;
        int   nl;
        logic [3:0] exp_pins;
        logic [3:0] got_pins;
        nl = n_latch[idx];
        for (int t = 0; t <= 17 * div; t++) begin
            @(negedge clk);
            k = t / (2 * div);
            if (k > 7) k = 7;
            exp_pins[3] = (t < 16 * div) && (((t / div) % 2) == 1);
            exp_pins[2] = (t >= 16 * div) && (t < 17 * div);
            exp_pins[1] = (t == 17 * div);
            exp_pins[0] = msb ? p[7-k] : p[k];
            got_pins    = {sr_clk[idx], sr_latch[idx], seg_ready[idx], sr_data[idx]};
            n_cmp++;
            if (got_pins !== exp_pins) begin
                n_err++;
                $display("FAIL waveform inst=%0d pat=%h t=%0d {clk,latch,ready,data}: got %b expected %b",
                         idx, p, t, got_pins, exp_pins);
            end
            if (t < 17 * div) seg_in[idx] = 8'($urandom);
            else              seg_valid[idx] = 1'b0;
        end
        n_cmp++;
        if (decode595(ql595[idx], msb) !== p) begin
            n_err++;
            $display("FAIL latched_value inst=%0d: got %h expected %h", idx, decode595(ql595[idx], msb), p);
        end
        n_cmp++;
        if (n_latch[idx] !== nl + 1) begin
            n_err++;
            $display("FAIL latch_count inst=%0d pat=%h: got %0d pulses expected 1", idx, p, n_latch[idx] - nl);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({sr_clk, sr_data, sr_latch, seg_ready} !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: got clk=%b data=%b latch=%b ready=%b expected all 0",
                     sr_clk, sr_data, sr_latch, seg_ready);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (seg_ready !== 4'hF) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b expected 1111", seg_ready);
        end
    endtask

    task automatic test_msb_first();
        bit ok;
        send_pattern(0, 8'h89, ok);
        if (ok) check_transfer(0, 8'h89, 2, 1'b1);
    endtask

    task automatic test_lsb_first();
        bit ok;
        send_pattern(1, 8'h86, ok);
        if (ok) check_transfer(1, 8'h86, 2, 1'b0);
    endtask

    task automatic test_skip_same();
        bit ok;
        int nr;
        int nl;
        send_pattern(0, 8'hC7, ok);
        if (ok) check_transfer(0, 8'hC7, 2, 1'b1);
        nr = n_rise[0];
        nl = n_latch[0];
        send_pattern(0, 8'hC7, ok);
        @(negedge clk);
        seg_valid[0] = 1'b0;
        n_cmp++;
        if ({seg_ready[0], sr_clk[0]} !== 2'b10) begin
            n_err++;
            $display("FAIL skip_idle: got ready=%b clk=%b expected ready=1 clk=0", seg_ready[0], sr_clk[0]);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if ((n_rise[0] !== nr) || (n_latch[0] !== nl)) begin
            n_err++;
            $display("FAIL skip_no_activity: got %0d rises %0d latches expected 0 and 0",
                     n_rise[0] - nr, n_latch[0] - nl);
        end
        send_pattern(0, 8'hC0, ok);
        if (ok) check_transfer(0, 8'hC0, 2, 1'b1);
    endtask

    task automatic test_first_after_reset();
        bit ok;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_pattern(0, 8'hFF, ok);
        if (ok) check_transfer(0, 8'hFF, 2, 1'b1);
    endtask

    task automatic test_reset_mid_transfer();
        bit ok;
        int nl;
        send_pattern(0, 8'h88, ok);
        if (ok) begin
            for (int t = 0; t <= 10; t++) @(negedge clk);
            n_cmp++;
            if (sr_clk[0] !== 1'b1) begin
                n_err++;
                $display("FAIL mid_clk_high: got sr_clk=%b at T0+10 expected 1", sr_clk[0]);
            end
            nl = n_latch[0];
            reset        = 1'b1;
            seg_valid[0] = 1'b0;
            #1;
            n_cmp++;
            if ({sr_clk[0], sr_data[0], sr_latch[0], seg_ready[0]} !== 4'b0000) begin
                n_err++;
                $display("FAIL mid_reset_pins: got clk=%b data=%b latch=%b ready=%b expected all 0",
                         sr_clk[0], sr_data[0], sr_latch[0], seg_ready[0]);
            end
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (40) @(negedge clk);
            n_cmp++;
            if (n_latch[0] !== nl) begin
                n_err++;
                $display("FAIL aborted_latch: got %0d pulses expected 0", n_latch[0] - nl);
            end
            send_pattern(0, 8'h88, ok);
            if (ok) check_transfer(0, 8'h88, 2, 1'b0 ^ 1'b1);
        end
    endtask

    task automatic test_random(input int idx, input int div, input bit msb);
        logic [7:0] exp_q[$];
        logic [7:0] last;
        logic [7:0] prev;
        logic [7:0] p;
        logic [7:0] got;
        bit         primed;
        bit         ok;
        int         base;
        base   = n_latch[idx];
        primed = 1'b0;
        last   = 8'hFF;
        prev   = 8'h00;
        for (int n = 0; n < 30; n++) begin
            p    = (n > 0 && $urandom_range(0, 2) == 0) ? prev : 8'($urandom);
            prev = p;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                seg_valid[idx] = 1'b0;
                seg_in[idx]    = 8'($urandom);
            end
            send_pattern(idx, p, ok);
            if (ok && !(primed && p == last)) begin
                exp_q.push_back(p);
                last   = p;
                primed = 1'b1;
            end
        end
        @(negedge clk);
        seg_valid[idx] = 1'b0;
        repeat (20 * div) @(negedge clk);
        n_cmp++;
        if (n_latch[idx] - base != exp_q.size()) begin
            n_err++;
            $display("FAIL random_count inst=%0d: got %0d latches expected %0d",
                     idx, n_latch[idx] - base, exp_q.size());
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            got = decode595(latch_log[idx][(base + j) % 256], msb);
            n_cmp++;
            if (got !== exp_q[j]) begin
                n_err++;
                $display("FAIL random_pattern inst=%0d #%0d: got %h expected %h", idx, j, got, exp_q[j]);
            end
        end
    endtask

    task automatic test_protocol();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (n_viol[i] != 0) begin
                n_err++;
                $display("FAIL data_while_clk_high inst=%0d: got %0d changes expected 0", i, n_viol[i]);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        seg_valid = '0;
        for (int i = 0; i < 4; i++) seg_in[i] = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_skip_same();
        test_first_after_reset();
        test_reset_mid_transfer();
        test_random(2, 1, 1'b1);
        test_random(3, 3, 1'b0);
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
